// File: rtl/uart_memory_dumper.sv
// Streams a range of 32-bit words from a synchronous memory read port out over an 8N1 UART,
// most-significant byte first. Optional trailing checksum frame: define UART_DUMP_CHECKSUM_EN.
module uart_memory_dumper #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                  iFpgaClock,
    input  logic                  iFpgaReset,
    input  logic                  iStartDump,
    input  logic [ADDR_WIDTH-1:0] iStartAddress,
    input  logic [ADDR_WIDTH:0]   iWordCount,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    input  logic [31:0]           iMemData,
    output logic                  oFpgaUartToPc,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] WordOne = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           shift_q, shift_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            cur_byte;
    logic                  tick;
`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  sum_phase_q, sum_phase_d;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        cur_byte = shift_q[{byte_idx_q, 3'b000} +: 8];
`ifdef UART_DUMP_CHECKSUM_EN
        if (sum_phase_q) begin
            cur_byte = sum_q;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = CntMax;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tx_d         = 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
        sum_d        = sum_q;
        sum_phase_d  = sum_phase_q;
`endif

        // The line register follows the state by one cycle, which places the start bit
        // three edges after acceptance and keeps oDone aligned with the end of the last stop bit.
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase

        unique case (state_q)
            StIdle: begin
                if (iStartDump) begin
                    busy_d       = 1'b1;
                    addr_d       = iStartAddress;
                    words_left_d = iWordCount;
`ifdef UART_DUMP_CHECKSUM_EN
                    sum_d        = 8'h00;
                    sum_phase_d  = 1'b0;
`endif
                    if (iWordCount != '0) begin
                        state_d = StFetch;
                    end else begin
`ifdef UART_DUMP_CHECKSUM_EN
                        sum_phase_d = 1'b1;
                        state_d     = StStart;
`else
                        state_d     = StDone;
`endif
                    end
                end
            end
            StFetch: state_d = StCapture;
            StCapture: begin
                shift_d    = iMemData;
                byte_idx_d = 2'd3;
                state_d    = StStart;
            end
            StStart: begin
                if (tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStop: begin
                if (tick) begin
`ifdef UART_DUMP_CHECKSUM_EN
                    if (!sum_phase_q) begin
                        sum_d = sum_q + cur_byte;
                    end
                    if (sum_phase_q) begin
                        state_d = StDone;
                    end else
`endif
                    if (byte_idx_q != 2'd0) begin
                        byte_idx_d = byte_idx_q - 2'd1;
                        state_d    = StStart;
                    end else if (words_left_q > WordOne) begin
                        words_left_d = words_left_q - WordOne;
                        addr_d       = addr_q + AddrOne;
                        state_d      = StFetch;
                    end else begin
`ifdef UART_DUMP_CHECKSUM_EN
                        sum_phase_d = 1'b1;
                        state_d     = StStart;
`else
                        state_d     = StDone;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
`ifdef UART_DUMP_CHECKSUM_EN
                sum_phase_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iFpgaClock) begin
        if (iFpgaReset) begin
            state_q      <= StIdle;
            cnt_q        <= CntMax;
            bit_idx_q    <= 3'd0;
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'h0;
            words_left_q <= '0;
            addr_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
            sum_q        <= 8'h00;
            sum_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef UART_DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
            sum_phase_q  <= sum_phase_d;
`endif
        end
    end

    assign oMemAddress   = addr_q;
    assign oFpgaUartToPc = tx_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;

endmodule

// File: tb/tb_uart_memory_dumper.sv
// Directed bench for uart_memory_dumper at 4 clocks per bit, with a UART decoder and memory model.
module tb_uart_memory_dumper;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Aw  = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [Aw-1:0] start_addr = '0;
    logic [Aw:0]   word_count = '0;
    logic [Aw-1:0] mem_addr;
    logic [31:0]   mem_data = 32'h0;
    logic          tx, busy, done;

    logic [31:0] mem [0:(1 << Aw) - 1];

    uart_memory_dumper #(
        .CLKS_PER_BIT (Cpb),
        .ADDR_WIDTH   (Aw)
    ) dut (
        .iFpgaClock    (clk),
        .iFpgaReset    (rst),
        .iStartDump    (start),
        .iStartAddress (start_addr),
        .iWordCount    (word_count),
        .oMemAddress   (mem_addr),
        .iMemData      (mem_data),
        .oFpgaUartToPc (tx),
        .oBusy         (busy),
        .oDone         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Decoder samples mid-bit, 2 time units after each edge.
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         done_cyc[$];
    int         n_low = 0;
    int         n_busy = 0;
    int         frame_err = 0;
    bit         mon_active = 1'b0;
    int         mon_k = 0;
    logic       mon_prev = 1'b1;
    logic [7:0] mon_sh = 8'h0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else begin
                if (!tx) n_low++;
                if (busy) n_busy++;
                if (done) done_cyc.push_back(cyc);
                if (!mon_active) begin
                    if (mon_prev && !tx) begin
                        mon_active = 1'b1;
                        mon_k      = 0;
                        rx_cyc.push_back(cyc);
                    end
                end else begin
                    mon_k++;
                    if (mon_k >= 5 && mon_k <= 33 && ((mon_k - 5) % 4) == 0)
                        mon_sh[(mon_k - 5) / 4] = tx;
                    if (mon_k == 37) begin
                        if (!tx) frame_err++;
                        rx_q.push_back(mon_sh);
                        mon_active = 1'b0;
                    end
                end
                mon_prev = tx;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        done_cyc.delete();
        n_low     = 0;
        n_busy    = 0;
        frame_err = 0;
    endtask

    task automatic launch(input logic [Aw-1:0] a, input logic [Aw:0] n, output int acc);
        start_addr = a;
        word_count = n;
        start      = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int t;
        t = 0;
        while (done_cyc.size() == 0 && t < limit) begin
            step(1);
            t++;
        end
        check({tag, "_finished"}, (done_cyc.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Expected bytes are rebuilt from the bench's own memory image.
    task automatic expect_dump(input string tag, input logic [Aw-1:0] a, input int nw);
        logic [7:0]  sum;
        logic [7:0]  exp_b;
        logic [31:0] w;
        int          nb;
        int          idx;
        sum = 8'h0;
        idx = 0;
        nb  = 4 * nw;
`ifdef UART_DUMP_CHECKSUM_EN
        nb = nb + 1;
`endif
        check({tag, "_nbytes"}, rx_q.size(), nb);
        check({tag, "_frame"}, frame_err, 0);
        check({tag, "_ndone"}, done_cyc.size(), 1);
        if (rx_q.size() == nb) begin
            for (int i = 0; i < nw; i++) begin
                w = mem[a + Aw'(i)];
                for (int b = 3; b >= 0; b--) begin
                    exp_b = w[8 * b +: 8];
                    sum   = sum + exp_b;
                    check({tag, "_byte"}, rx_q[idx], exp_b);
                    idx++;
                end
            end
`ifdef UART_DUMP_CHECKSUM_EN
            check({tag, "_sum"}, rx_q[idx], sum);
`endif
        end
        if (nw > 0 && done_cyc.size() != 0 && rx_cyc.size() != 0)
            check({tag, "_done_at"}, done_cyc[0] - rx_cyc[0], 40 * nb + 2 * (nw - 1));
    endtask

    int acc;

    initial begin
        for (int i = 0; i < (1 << Aw); i++) mem[i] = 32'h0;
        mem[14'h0010] = 32'h1234_5678;
        mem[14'h3FFF] = 32'hA5C3_0F81;
        mem[14'h0000] = 32'hDEAD_BEEF;
        mem[14'h0020] = 32'h0BAD_F00D;
        mem[14'h0040] = 32'h0102_0304;
        mem[14'h0041] = 32'hFF00_0001;

        // Reset and idle
        rst = 1'b1;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;
        clear_mon();
        step(50);
        check("idle_low", n_low, 0);
        check("idle_busy", n_busy, 0);
        check("idle_done", done_cyc.size(), 0);

        // Single word
        clear_mon();
        launch(14'h0010, 15'd1, acc);
        check("t1_busy_accept", busy, 1);
        check("t1_addr", mem_addr, 14'h0010);
        wait_done("t1", 400);
        step(5);
        if (rx_cyc.size() != 0) check("t1_start_lat", rx_cyc[0] - acc, 3);
        check("t1_busy_end", busy, 0);
        expect_dump("t1", 14'h0010, 1);

        // Address wrap across two words
        clear_mon();
        launch(14'h3FFF, 15'd2, acc);
        check("t2_addr0", mem_addr, 14'h3FFF);
        wait_done("t2", 800);
        step(5);
        check("t2_addr1", mem_addr, 14'h0000);
        expect_dump("t2", 14'h3FFF, 2);
        if (rx_cyc.size() >= 5) begin
            check("t2_byte_gap", rx_cyc[1] - rx_cyc[0], 40);
            check("t2_word_gap", rx_cyc[4] - rx_cyc[3], 42);
        end

        // Zero-word dump
        clear_mon();
        launch(14'h0005, 15'd0, acc);
        check("t3_busy", busy, 1);
        check("t3_done_early", done, 0);
`ifdef UART_DUMP_CHECKSUM_EN
        wait_done("t3", 200);
        step(5);
        expect_dump("t3", 14'h0005, 0);
`else
        step(1);
        check("t3_busy_drop", busy, 0);
        check("t3_done", done, 1);
        step(20);
        check("t3_low", n_low, 0);
        check("t3_ndone", done_cyc.size(), 1);
`endif

        // Start pulse during a transfer is ignored
        clear_mon();
        launch(14'h0020, 15'd1, acc);
        step(50);
        start_addr = 14'h3FFF;
        word_count = 15'd2;
        start      = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("t4", 400);
        step(60);
        expect_dump("t4", 14'h0020, 1);

        // Reset during a data bit, then a clean dump
        clear_mon();
        launch(14'h0010, 15'd1, acc);
        step(7);
        check("t5_low_bit0", tx, 0);
        rst = 1'b1;
        step(1);
        check("t5_tx_high", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        rst = 1'b0;
        step(5);
        clear_mon();
        launch(14'h0010, 15'd1, acc);
        wait_done("t5", 400);
        step(5);
        expect_dump("t5", 14'h0010, 1);

`ifdef UART_DUMP_CHECKSUM_EN
        // Checksum frame
        clear_mon();
        launch(14'h0040, 15'd2, acc);
        wait_done("t6", 800);
        step(5);
        expect_dump("t6", 14'h0040, 2);
        if (rx_q.size() == 9) check("t6_sum_value", rx_q[8], 8'h0A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
